// File: rtl/custom_rr_arbiter.sv
// custom_rr_arbiter: round-robin arbiter sharing one custom::struct1 channel
// among NUM_REQ valid/ready requesters, with a one-entry registered output
// stage tagged with the winner's index.
// Optional feature: define ARB_LOCK_EN to honour req_lock. A locked requester
// keeps the grant for up to MAX_HOLD consecutive beats before rotation is forced.

package custom;

    // Generic 8-bit beat payload carried through the arbiter
    typedef struct packed {
        logic [1:0] field;
        logic [5:0] tag;
    } struct1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY   = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

endpackage

module custom_rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  custom::struct1 [NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_lock,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    output custom::struct1               out_data,
    output logic [$clog2(NUM_REQ)-1:0]   out_id,
    input  logic                         out_ready,
    output custom::arb_state_e           arb_state,
    output logic [7:0]                   grant_count
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned SUM_W = ID_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
`ifdef ARB_LOCK_EN
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [8:0] HOLD_LIM  = 9'(MAX_HOLD);
`endif

    logic                 out_valid_q, out_valid_d;
    custom::struct1       out_data_q,  out_data_d;
    logic [ID_W-1:0]      out_id_q,    out_id_d;
    logic [ID_W-1:0]      ptr_q,       ptr_d;
    logic [7:0]           cnt_q,       cnt_d;
    logic [1:0]           state_q,     state_d;
`ifdef ARB_LOCK_EN
    logic [7:0]           hold_q,      hold_d;
    logic [ID_W-1:0]      lock_id_q,   lock_id_d;
    logic [8:0]           hold_inc;
`else
    logic                 unused_lock;
    localparam int unsigned unused_max_hold = MAX_HOLD;
    assign unused_lock = ^req_lock;
`endif

    logic                 acc;
    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [SUM_W-1:0]     search_sum;
    logic [ID_W-1:0]      search_idx;
    logic                 grant;

    assign acc = !out_valid_q || out_ready;

    // Winner search: first valid index after ptr, or only lock_id while locked
    always_comb begin
        win_found  = 1'b0;
        win_id     = '0;
        search_sum = '0;
        search_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            search_sum = {1'b0, ptr_q} + SUM_W'(k);
            if (search_sum >= SUM_W'(NUM_REQ)) begin
                search_sum = search_sum - SUM_W'(NUM_REQ);
            end
            search_idx = search_sum[ID_W-1:0];
            if (!win_found && req_valid[search_idx]) begin
                win_found = 1'b1;
                win_id    = search_idx;
            end
        end
`ifdef ARB_LOCK_EN
        if (state_q == ST_LOCKED) begin
            win_found = req_valid[lock_id_q];
            win_id    = lock_id_q;
        end
`endif
    end

    assign grant     = win_found && acc;
    assign req_ready = grant ? (NUM_REQ'(1) << win_id) : '0;

    // Next-state: output stage load/drain, pointer, counter and FSM
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
`ifdef ARB_LOCK_EN
        hold_d      = hold_q;
        lock_id_d   = lock_id_q;
        hold_inc    = {1'b0, hold_q} + 9'd1;
`endif
        if (grant) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[win_id];
            out_id_d    = win_id;
            ptr_d       = win_id;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
            state_d = ST_BUSY;
`ifdef ARB_LOCK_EN
            if (state_q == ST_LOCKED) begin
                // Stay locked only while requested and under the hold limit
                if (req_lock[win_id] && (hold_inc < HOLD_LIM)) begin
                    state_d = ST_LOCKED;
                    hold_d  = hold_inc[7:0];
                end else begin
                    hold_d  = '0;
                end
            end else if (req_lock[win_id] && (9'd1 < HOLD_LIM)) begin
                // Entry grant is the first of the locked run
                state_d   = ST_LOCKED;
                lock_id_d = win_id;
                hold_d    = 8'd1;
            end
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            if (state_q == ST_BUSY) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
`ifdef ARB_LOCK_EN
            hold_q      <= '0;
            lock_id_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
`ifdef ARB_LOCK_EN
            hold_q      <= hold_d;
            lock_id_q   <= lock_id_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_id      = out_id_q;
    assign arb_state   = custom::arb_state_e'(state_q);
    assign grant_count = cnt_q;

endmodule

// File: doc/custom_rr_arbiter.md
# custom_rr_arbiter

Round-robin arbiter that shares a single downstream `custom::struct1` channel among `NUM_REQ` requesters. Each requester presents a valid/ready stream of `custom::struct1` payloads. The arbiter grants one beat per cycle into a one-entry registered output stage tagged with the winner's index. It sits in front of any shared consumer of `custom::struct1` traffic and uses the `custom` package types directly.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `MAX_HOLD`, default 7: maximum consecutive locked grants before forced rotation (used only with `ARB_LOCK_EN`), legal range 1..255.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  [NUM_REQ-1:0]  per-requester valid.
- `req_data`  in  `custom::struct1 [NUM_REQ-1:0]`  per-requester payload (packed array of struct).
- `req_lock`  in  [NUM_REQ-1:0]  per-requester lock request; ignored without `ARB_LOCK_EN`.
- `req_ready`  out  [NUM_REQ-1:0]  one-hot or zero grant/accept.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  `custom::struct1`  granted payload.
- `out_id`  out  $clog2(NUM_REQ)  index of the granted requester.
- `out_ready`  in  1  downstream accept.
- `arb_state`  out  `custom::arb_state_e`  current FSM state. Encoding is added to package `custom`: `logic [1:0]`, `ARB_IDLE=0`, `ARB_BUSY=1`, `ARB_LOCKED=2`.
- `grant_count`  out  8  saturating count of grants.

## Operation
- **Accept condition:** `acc = !out_valid || out_ready`.
- **Winner selection:**
  - Search order is `ptr+1, ptr+2, …` modulo `NUM_REQ`; the winner is the first index with `req_valid` set.
  - `ptr` holds the last granted index.
  - In `ARB_LOCKED`, the only candidate is `lock_id`.
- **Grant:**
  - `req_ready[w] = acc && req_valid[w]`; all other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready` and state.
  - `req_ready` never depends on `req_data`.
- **On a grant, at the next edge:**
  - `out_data <= req_data[w]`, `out_id <= w`, `out_valid <= 1`.
  - `ptr <= w`.
  - `grant_count` increments, saturating at 255.
- **No grant:** if `out_valid && out_ready` and there is no grant, then `out_valid <= 0`.
- **FSM:**
  - `ARB_IDLE` (`out_valid=0`) → `ARB_BUSY` on any grant.
  - `ARB_BUSY` → `ARB_IDLE` when the output drains with no new grant.
  - `ARB_BUSY` / `ARB_IDLE` → `ARB_LOCKED` on a grant with `req_lock[w]=1` (macro only).
  - `ARB_LOCKED` → `ARB_BUSY` when:
    - a grant to `lock_id` has `req_lock=0`, or
    - `hold_cnt` reaches `MAX_HOLD`.
  - In `ARB_LOCKED`, requests from other indices are ignored, even if `lock_id` is idle.
- **Simultaneous drain and grant:** the register reloads in the same edge, so back-to-back beats are possible with no bubble.

## Timing
- **Reset values:** `out_valid=0`, `out_data='0`, `out_id=0`, `arb_state=ARB_IDLE`, `grant_count=0`, `ptr=NUM_REQ-1` (requester 0 has first priority), `hold_cnt=0`, `lock_id=0`.
- **Async reset mid-operation:** all of the above apply immediately; the held beat is discarded.
- **Latency:** 1 cycle from the `req_valid && req_ready` edge to `out_valid`.
- **Throughput:** 1 beat per cycle while `out_ready=1`.
- **Stall:** while `out_valid && !out_ready`, `out_data` and `out_id` stay stable and all `req_ready` bits are 0.
- **Wrap:** `ptr = NUM_REQ-1` searches index 0 first.
- **Counter:** `grant_count` holds at 255.

## Configuration
- `ARB_LOCK_EN` defined:
  - `req_lock` is honoured and the `ARB_LOCKED` state is reachable.
  - `hold_cnt` (8-bit) counts consecutive locked grants and resets on exiting `ARB_LOCKED`.
  - On forced exit, `ptr` advances normally, so the next search starts at `lock_id+1`.
- `ARB_LOCK_EN` undefined:
  - `req_lock` is unused.
  - `ARB_LOCKED` is never entered.
  - `hold_cnt` and `lock_id` are removed.

## Test plan
- **Reset:** `rst_n` low mid-traffic → `out_valid=0`, `arb_state=ARB_IDLE`, `grant_count=0` immediately. First grant after release goes to requester 0 when all four requesters are valid.
- **Round-robin fairness:** `NUM_REQ=4`, all valid continuously, `out_ready=1` → `out_id` sequence is 0,1,2,3,0,…; one beat per cycle; `arb_state` stays `ARB_BUSY`.
- **Stall:** `out_ready=0` for 3 cycles with `out_data.field=2'b10` held → `out_data` stable and `req_ready=0` throughout. On `out_ready=1`, the next winner is loaded in the same edge.
- **Wrap and sparse requests:** only requesters 1 and 3 valid, `ptr=3` → grant 1, then 3, then 1.
- **Lock (with `ARB_LOCK_EN`, `MAX_HOLD=3`):** requester 2 holds `req_lock=1` with others valid → exactly 3 consecutive grants to id 2, then `ARB_BUSY` and the next grant goes to id 3. Without the macro → normal rotation.
- **Saturation:** 300 grants → `grant_count=255`.
